// File: rtl/forward_scoreboard_if.sv
// ID-stage request and hazard/forwarding response bundle for forward_scoreboard.
// The slave side is the scoreboard; the master side is the pipeline control.
interface forward_scoreboard_if #(
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned DEPTH   = 3
);
  localparam int unsigned SELW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic                      hold_i;
  logic                      flush_i;
  logic                      id_valid_i;
  logic                      id_regwrite_i;
  logic                      id_memread_i;
  logic [4:0]                id_rd_i;
  logic [5*NUM_SRC-1:0]      id_rs_i;
  logic [NUM_SRC-1:0]        id_use_i;
  logic                      stall_o;
  logic [SELW*NUM_SRC-1:0]   fwd_sel_o;
  logic                      ex_valid_o;
  logic [15:0]               stall_cnt_o;

  modport slave (
    input  hold_i, flush_i, id_valid_i, id_regwrite_i, id_memread_i,
           id_rd_i, id_rs_i, id_use_i,
    output stall_o, fwd_sel_o, ex_valid_o, stall_cnt_o
  );

  modport master (
    output hold_i, flush_i, id_valid_i, id_regwrite_i, id_memread_i,
           id_rd_i, id_rs_i, id_use_i,
    input  stall_o, fwd_sel_o, ex_valid_o, stall_cnt_o
  );
endinterface

// File: rtl/forward_scoreboard.sv
// Tracks destination registers of in-flight instructions after ID, raises the
// load-use stall and selects the forwarding source for each EX operand.
module forward_scoreboard #(
  parameter int unsigned NUM_SRC    = 2,
  parameter int unsigned DEPTH      = 3,
  parameter int unsigned LOAD_READY = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  forward_scoreboard_if.slave  bus
);
  localparam int unsigned SELW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic       valid;
    logic       regwrite;
    logic       load;
    logic [4:0] rd;
  } slot_t;

  slot_t                   slot_q   [DEPTH];
  slot_t                   slot_d   [DEPTH];
  logic [4:0]              ex_rs_q  [NUM_SRC];
  logic [4:0]              ex_rs_d  [NUM_SRC];
  logic [NUM_SRC-1:0]      ex_use_q;
  logic [NUM_SRC-1:0]      ex_use_d;
  logic [15:0]             cnt_q;
  logic [15:0]             cnt_d;
  logic                    stall;
  logic                    load_id;
  logic [SELW*NUM_SRC-1:0] fwd_sel;

  // Loads younger than LOAD_READY-1 cannot supply data in time for ID's consumer.
  always_comb begin
    stall = 1'b0;
    if (bus.id_valid_i && !bus.flush_i) begin
      for (int unsigned j = 0; j < NUM_SRC; j++) begin
        for (int unsigned k = 0; (k + 1 < LOAD_READY) && (k < DEPTH); k++) begin
          if (bus.id_use_i[j] && slot_q[k].valid && slot_q[k].load &&
              slot_q[k].regwrite && (slot_q[k].rd != '0) &&
              (slot_q[k].rd == bus.id_rs_i[5*j +: 5]))
            stall = 1'b1;
        end
      end
    end
  end

  assign load_id = bus.id_valid_i && !bus.flush_i && !stall;

  always_comb begin
    for (int unsigned k = 0; k < DEPTH; k++) slot_d[k] = slot_q[k];
    for (int unsigned j = 0; j < NUM_SRC; j++) ex_rs_d[j] = ex_rs_q[j];
    ex_use_d = ex_use_q;
    cnt_d    = cnt_q;
    if (!bus.hold_i) begin
      for (int unsigned k = 1; k < DEPTH; k++) slot_d[k] = slot_q[k-1];
      if (load_id) begin
        slot_d[0].valid    = 1'b1;
        slot_d[0].regwrite = bus.id_regwrite_i;
        slot_d[0].load     = bus.id_memread_i;
        slot_d[0].rd       = bus.id_rd_i;
        for (int unsigned j = 0; j < NUM_SRC; j++) ex_rs_d[j] = bus.id_rs_i[5*j +: 5];
        ex_use_d = bus.id_use_i;
      end else begin
        slot_d[0] = '0;
        for (int unsigned j = 0; j < NUM_SRC; j++) ex_rs_d[j] = '0;
        ex_use_d = '0;
      end
      if (stall && (cnt_q != '1)) cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned k = 0; k < DEPTH; k++) slot_q[k] <= '0;
      for (int unsigned j = 0; j < NUM_SRC; j++) ex_rs_q[j] <= '0;
      ex_use_q <= '0;
      cnt_q    <= '0;
    end else begin
      for (int unsigned k = 0; k < DEPTH; k++) slot_q[k] <= slot_d[k];
      for (int unsigned j = 0; j < NUM_SRC; j++) ex_rs_q[j] <= ex_rs_d[j];
      ex_use_q <= ex_use_d;
      cnt_q    <= cnt_d;
    end
  end

  // Youngest eligible producer wins; loads not yet at LOAD_READY are skipped.
  always_comb begin : fwd_select
    logic found;
    fwd_sel = '0;
    found   = 1'b0;
    for (int unsigned j = 0; j < NUM_SRC; j++) begin
      found = 1'b0;
      for (int unsigned k = 1; k < DEPTH; k++) begin
        if (!found && ex_use_q[j] && slot_q[k].valid && slot_q[k].regwrite &&
            (slot_q[k].rd != '0) && (slot_q[k].rd == ex_rs_q[j]) &&
            (!slot_q[k].load || (k >= LOAD_READY))) begin
          fwd_sel[SELW*j +: SELW] = SELW'(k);
          found = 1'b1;
        end
      end
    end
  end

  assign bus.stall_o     = stall;
  assign bus.fwd_sel_o   = fwd_sel;
  assign bus.ex_valid_o  = slot_q[0].valid;
  assign bus.stall_cnt_o = cnt_q;
endmodule

// File: doc/forward_scoreboard.md
FORWARD_SCOREBOARD -- requirements
Module: forward_scoreboard

Interface
REQ-001 SHALL have parameter NUM_SRC, default 2: number of source-operand ports per instruction.
REQ-002 SHALL have parameter DEPTH, default 3: tracked pipeline slots after ID; slot 0=EX, 1=MEM, 2=WB.
REQ-003 SHALL have parameter LOAD_READY, default 2: first slot index from which load data is forwardable; legal range 1..DEPTH-1.
REQ-004 SHALL derive SELW = clog2(DEPTH), minimum 1, as the width of each forward-select field.
REQ-005 SHALL use one clock, clk_i; reset is asynchronous and active-high, rst_i.
REQ-006 SHALL have ports:
  clk_i  in  1  clock, rising edge.
  rst_i  in  1  asynchronous active-high reset.
  hold_i  in  1  global pipeline freeze.
  flush_i  in  1  squash the ID instruction.
  id_valid_i  in  1  ID holds a real instruction.
  id_regwrite_i  in  1  ID instruction writes rd.
  id_memread_i  in  1  ID instruction is a load.
  id_rd_i  in  5  ID destination register.
  id_rs_i  in  5*NUM_SRC  ID source registers; source j at bits [5j+4:5j].
  id_use_i  in  NUM_SRC  per-source "operand actually read" mask.
  stall_o  out  1  load-use stall request to ID/IF.
  fwd_sel_o  out  SELW*NUM_SRC  per-source forward select for the EX instruction.
  ex_valid_o  out  1  slot 0 holds a real instruction.
  stall_cnt_o  out  16  saturating count of stall cycles.

Function
REQ-007 SHALL keep DEPTH slot entries {valid, regwrite, load, rd} plus NUM_SRC registered EX sources {rs, use}, registered from id_rs_i/id_use_i when slot 0 loads.
REQ-008 SHALL, on every rising edge with hold_i=0, shift slot k-1 into slot k for k=1..DEPTH-1 and discard the old slot DEPTH-1.
REQ-009 SHALL, on the same edge, load slot 0 from ID if id_valid_i=1, flush_i=0 and stall_o=0; otherwise load a bubble (valid=0, regwrite=0, rs=0, use=0).
REQ-010 SHALL freeze all slots, EX sources and stall_cnt_o while hold_i=1.
REQ-011 SHALL assert stall_o combinationally when id_valid_i=1, flush_i=0 and, for some source j with id_use_i[j]=1, some slot k in 0..LOAD_READY-2 holds valid=1, load=1, regwrite=1, rd!=0, rd==rs_j.
REQ-012 SHALL treat rd==0 as never matching, for both stall and forwarding.
REQ-013 SHALL, for each EX source j, set fwd_sel field j to the smallest k in 1..DEPTH-1 whose slot has valid=1, regwrite=1, rd!=0, rd==rs_j and (load=0 or k>=LOAD_READY); 0 (register file) if none or use=0.
REQ-014 SHALL give the youngest slot priority: a match in slot k masks all matches in slots >k.
REQ-015 SHALL compute fwd_sel_o combinationally from registered state only; zero additional latency relative to EX.
REQ-016 SHALL drive ex_valid_o = slot 0 valid.
REQ-017 SHALL increment stall_cnt_o on each edge with stall_o=1 and hold_i=0, saturating at 16'hFFFF.
REQ-018 SHALL give flush_i priority over stall: flush_i=1 forces stall_o=0 and a bubble into slot 0.

Reset
REQ-019 SHALL, while rst_i=1, clear all slots and EX sources, giving stall_o=0, fwd_sel_o=0, ex_valid_o=0 and stall_cnt_o=0, independent of clk_i.
REQ-020 SHALL discard in-flight entries on reset mid-operation; no forwarding from pre-reset instructions after release.

Verification
REQ-021 ALU chain: issue add x5 then sub using rs1=x5, rs2=x5 on the next cycle -> when sub is in EX, fwd_sel = 1/1 (MEM), stall_o=0.
REQ-022 Load-use: issue lw x7, then add rs1=x7 -> stall_o=1 for one cycle and a bubble enters EX; add then enters EX with fwd_sel0=2 (WB); stall_cnt_o=1.
REQ-023 Priority: writes to x3 at slots 1 and 2, EX rs2=x3 -> fwd_sel1=1; x0 write with rs=x0 -> fwd_sel=0.
REQ-024 Hold/flush: hold_i=1 for 3 cycles during a load-use stall -> slots, fwd_sel_o and stall_cnt_o unchanged; flush_i=1 with a hazard -> stall_o=0 and ex_valid_o=0 next cycle.
REQ-025 Reset mid-stream: assert rst_i asynchronously with 3 valid slots -> all outputs 0 immediately; stall_cnt_o forced to 16'hFFFF by continuous stalls stays at 16'hFFFF.
REQ-026 Parameter sweep: NUM_SRC=3, DEPTH=4, LOAD_READY=3 -> a load in slot 0 or 1 stalls a dependent ID instruction, and a load in slot 1 is never selected for forwarding.
